// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared ALU.
// Each operation takes three cycles: IDLE (arbitrate and latch operands),
// ISSUE (alu_enbl high, winner sees gnt, carry sampled) and CAPTURE
// (result presented, winner sees done).
// Optional build macro ALU_ARBITER_FIXED_PRIORITY_EN: requester 0 always wins
// a tie and no round-robin pointer exists. Without it, arbitration is round-robin.
//
// Handshake: a requester holds req with its operands stable until it sees
// gnt (one cycle, during ISSUE). Operands are latched at the edge that
// starts ISSUE, so the requester may change them from the cycle after gnt.
// done marks the single CAPTURE cycle in which result/cout belong to it.
// Nothing applies backpressure to done.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_enbl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           cur, nxt;
    logic             any_req;
    logic             winner;   // 0 = requester 0, 1 = requester 1
    logic             owner;    // requester that owns the in-flight operation
    logic [WIDTH-1:0] opa, opb, res_q;
    logic [2:0]       opc;
    logic             ocin, cout_q;

    assign any_req = req0 | req1;

`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
    // Fixed priority: requester 1 wins only when requester 0 is not asking.
    always_comb winner = ~req0;
`else
    logic ptr;   // preferred requester on a tie

    // Round-robin pick: a sole requester always wins, a tie goes to ptr.
    always_comb begin
        winner = ptr;
        if (req0 && !req1)
            winner = 1'b0;
        else if (req1 && !req0)
            winner = 1'b1;
    end

    // After every grant, prefer the requester that did not win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= 1'b0;
        else if (cur == IDLE && any_req)
            ptr <= ~winner;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        nxt      = cur;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        alu_enbl = 1'b0;
        result   = res_q;
        case (cur)
            IDLE: begin
                if (any_req)
                    nxt = ISSUE;
            end
            ISSUE: begin
                nxt      = CAPTURE;
                alu_enbl = 1'b1;
                gnt0     = ~owner;
                gnt1     = owner;
            end
            CAPTURE: begin
                nxt    = IDLE;
                result = alu_result;
                done0  = ~owner;
                done1  = owner;
            end
            default: nxt = IDLE;
        endcase
    end

    // Operand latch on accept, carry sample in ISSUE, result hold in CAPTURE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opa    <= '0;
            opb    <= '0;
            opc    <= '0;
            ocin   <= 1'b0;
            owner  <= 1'b0;
            cout_q <= 1'b0;
            res_q  <= '0;
        end else begin
            if (cur == IDLE && any_req) begin
                opa   <= winner ? a1   : a0;
                opb   <= winner ? b1   : b0;
                opc   <= winner ? op1  : op0;
                ocin  <= winner ? cin1 : cin0;
                owner <= winner;
            end
            if (cur == ISSUE)
                cout_q <= alu_cout;
            if (cur == CAPTURE)
                res_q <= alu_result;
        end
    end

    assign alu_a     = opa;
    assign alu_b     = opb;
    assign alu_op    = opc;
    assign alu_cin   = ocin;
    assign cout      = cout_q;
    assign dbg_state = cur;

endmodule
